// File: rtl/phys_reg_tracker_if.sv
// phys_reg_tracker_if: dispatch, retire, CDB and branch-stack signals of the register tracker
interface phys_reg_tracker_if #(
  parameter int N         = 3,
  parameter int NUM_PREGS = 64,
  parameter int NUM_CKPT  = 4
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(NUM_CKPT);
  localparam int SW = $clog2(N + 1);
  localparam int FW = $clog2(NUM_PREGS + 1);
  logic [SW-1:0]        alloc_req;
  logic [SW-1:0]        alloc_count;
  logic [N-1:0][PW-1:0] alloc_idx;
  logic [FW-1:0]        free_count;
  logic [N-1:0]         retire_valid;
  logic [N-1:0][PW-1:0] retire_idx;
  logic [N-1:0]         complete_valid;
  logic [N-1:0][PW-1:0] complete_idx;
  logic [NUM_PREGS-1:0] ready_list;
  logic                 ckpt_save;
  logic [CW-1:0]        ckpt_id;
  logic                 ckpt_full;
  logic                 ckpt_release;
  logic [CW-1:0]        release_id;
  logic                 restore;
  logic [CW-1:0]        restore_id;
  modport master (
    output alloc_req, retire_valid, retire_idx, complete_valid, complete_idx,
           ckpt_save, ckpt_release, release_id, restore, restore_id,
    input  alloc_count, alloc_idx, free_count, ready_list, ckpt_id, ckpt_full
  );
  modport slave (
    input  alloc_req, retire_valid, retire_idx, complete_valid, complete_idx,
           ckpt_save, ckpt_release, release_id, restore, restore_id,
    output alloc_count, alloc_idx, free_count, ready_list, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/phys_reg_tracker.sv
// phys_reg_tracker: free list, ready list and branch checkpoints for an R10K-style rename stage
module phys_reg_tracker #(
  parameter int N         = 3,
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int NUM_CKPT  = 4
) (
  input logic               clk,
  input logic               rst,
  phys_reg_tracker_if.slave bus
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(NUM_CKPT);
  localparam int SW = $clog2(N + 1);
  localparam int FW = $clog2(NUM_PREGS + 1);
  localparam logic [NUM_PREGS-1:0] RESET_FREE = {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
  logic [NUM_PREGS-1:0] free_q, free_d, ready_q, ready_d, free_nxt;
  logic [NUM_PREGS-1:0] alloc_mask, retire_mask, complete_mask;
  logic [NUM_CKPT-1:0] valid_q, valid_d, kill, rel_vec;
  logic [NUM_CKPT-1:0][NUM_PREGS-1:0] snap_q, snap_d;
  logic [NUM_CKPT-1:0][NUM_CKPT-1:0] older_q, older_d;
  logic [SW-1:0] req, cnt;
  logic [N-1:0][PW-1:0] idx;
  logic [FW-1:0] fc;
  logic [CW-1:0] cid;
  logic save_ok;
  // Grant the lowest free registers; a mispredict cycle grants nothing
  always_comb begin
    req = bus.restore ? '0 : (bus.alloc_req > SW'(N) ? SW'(N) : bus.alloc_req);
    cnt = '0;
    idx = '0;
    alloc_mask = '0;
    for (int i = 0; i < NUM_PREGS; i++)
      if (free_q[i] && cnt < req) begin
        idx[cnt] = PW'(i);
        alloc_mask[i] = 1'b1;
        cnt = cnt + SW'(1);
      end
  end
  // Free-register count and lowest invalid checkpoint slot
  always_comb begin
    fc = '0;
    cid = '0;
    for (int i = 0; i < NUM_PREGS; i++) fc = fc + FW'(free_q[i]);
    for (int s = NUM_CKPT - 1; s >= 0; s--) if (!valid_q[s]) cid = CW'(s);
  end
  // Merge retire and CDB lanes into masks; duplicate indices simply OR together
  always_comb begin
    retire_mask = '0;
    complete_mask = '0;
    for (int l = 0; l < N; l++) begin
      if (bus.retire_valid[l]) retire_mask[bus.retire_idx[l]] = 1'b1;
      if (bus.complete_valid[l]) complete_mask[bus.complete_idx[l]] = 1'b1;
    end
  end
  // Next state: retires survive restores by being folded into every snapshot
  always_comb begin
    free_nxt = free_q & ~alloc_mask | retire_mask;
    free_d = bus.restore ? (snap_q[bus.restore_id] | retire_mask) : free_nxt;
    ready_d = ready_q & ~alloc_mask | complete_mask;
    kill = '0;
    rel_vec = '0;
    for (int s = 0; s < NUM_CKPT; s++)
      kill[s] = bus.restore && (CW'(s) == bus.restore_id || older_q[s][bus.restore_id]);
    if (bus.ckpt_release && valid_q[bus.release_id] && !kill[bus.release_id]) rel_vec[bus.release_id] = 1'b1;
    save_ok = bus.ckpt_save && !bus.restore && !(&valid_q);
    valid_d = valid_q & ~kill & ~rel_vec;
    for (int s = 0; s < NUM_CKPT; s++) begin
      snap_d[s] = snap_q[s] | retire_mask;
      older_d[s] = older_q[s] & ~rel_vec;
    end
    if (save_ok) begin
      valid_d[cid] = 1'b1;
      snap_d[cid] = free_nxt;
      older_d[cid] = valid_q & ~rel_vec;
    end
  end
  // State registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      free_q <= RESET_FREE;
      ready_q <= '1;
      valid_q <= '0;
      snap_q <= '0;
      older_q <= '0;
    end else begin
      free_q <= free_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      snap_q <= snap_d;
      older_q <= older_d;
    end
  assign bus.alloc_count = cnt;
  assign bus.alloc_idx = idx;
  assign bus.free_count = fc;
  assign bus.ready_list = ready_q;
  assign bus.ckpt_id = cid;
  assign bus.ckpt_full = &valid_q;
endmodule
